universal_shift_engine: RTL and testbench

UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

---
 rtl/universal_shift_engine.sv | 141 ++++++++++++++
 tb/tb_universal_shift_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_engine.sv
// Universal shift register engine: parallel load/clear plus multi-cycle
// shift/rotate commands, each reporting completion with a one-cycle done pulse.
module universal_shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] shift_n,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SHR   = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ASR   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       op_r, op_s;
    logic [WIDTH-1:0] p_r, p_s;
    logic             done_r, done_s;

    // One single-bit step of a shift-class op; non-shift codes leave data alone.
    function automatic logic [WIDTH-1:0] shift_apply(
        input logic [2:0]       op_f,
        input logic [WIDTH-1:0] p_f,
        input logic             sl_f,
        input logic             sr_f
    );
        logic [WIDTH-1:0] r;
        case (op_f)
            OP_SHR:  r = {sr_f, p_f[WIDTH-1:1]};
            OP_SHL:  r = {p_f[WIDTH-2:0], sl_f};
            OP_ROR:  r = {p_f[0], p_f[WIDTH-1:1]};
            OP_ROL:  r = {p_f[WIDTH-2:0], p_f[WIDTH-1]};
            OP_ASR:  r = {p_f[WIDTH-1], p_f[WIDTH-1:1]};
            default: r = p_f;
        endcase
        return r;
    endfunction

    // Next-state, counter, latched-op, data and done computation.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        p_s     = p_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP: begin
                            done_s = 1'b1;
                        end
                        OP_LOAD: begin
                            p_s    = p_din;
                            done_s = 1'b1;
                        end
                        OP_CLEAR: begin
                            p_s    = {WIDTH{1'b0}};
                            done_s = 1'b1;
                        end
                        default: begin
                            // A zero-length shift completes at once like a NOP.
                            if (shift_n == CNT_ZERO) begin
                                done_s = 1'b1;
                            end else begin
                                op_s    = op;
                                cnt_s   = shift_n;
                                state_s = SHIFT;
                            end
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                p_s   = shift_apply(op_r, p_r, s_left_din, s_right_din);
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            op_r    <= OP_NOP;
            p_r     <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            p_r     <= p_s;
            done_r  <= done_s;
        end
    end

    assign p_dout       = p_r;
    assign s_left_dout  = p_r[0];
    assign s_right_dout = p_r[WIDTH-1];
    assign busy         = (state_r == SHIFT);
    assign done         = done_r;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed, table-driven bench for universal_shift_engine (WIDTH=8, CNT_W=4).
module tb_universal_shift_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] shift_n = 4'd0;
    logic [7:0] p_din = 8'h00;
    logic       s_left_din = 1'b0;
    logic       s_right_din = 1'b0;
    logic [7:0] p_dout;
    logic       s_left_dout;
    logic       s_right_dout;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    universal_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .shift_n(shift_n),
        .p_din(p_din), .s_left_din(s_left_din), .s_right_din(s_right_din),
        .p_dout(p_dout), .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] n;
        logic [7:0] init;
        logic [7:0] din;
        logic       sl;
        logic       sr;
        logic [7:0] exp;
        int         cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a command for exactly one rising edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] o, input logic [3:0] n, input logic [7:0] d);
        start   = 1'b1;
        op      = o;
        shift_n = n;
        p_din   = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Count busy samples until done appears, bounded.
    task automatic wait_done(input string name, output int busy_cnt);
        int guard;
        busy_cnt = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) busy_cnt++;
            step();
            guard++;
        end
        chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int bc;
        string nm;
        vecs[0]  = '{3'd3, 4'd0,  8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5, 0};
        vecs[1]  = '{3'd1, 4'd3,  8'hA5, 8'h00, 1'b0, 1'b1, 8'hF4, 3};
        vecs[2]  = '{3'd2, 4'd2,  8'h81, 8'h00, 1'b1, 1'b0, 8'h07, 2};
        vecs[3]  = '{3'd5, 4'd4,  8'hA5, 8'h00, 1'b0, 1'b0, 8'h5A, 4};
        vecs[4]  = '{3'd6, 4'd2,  8'h80, 8'h00, 1'b0, 1'b0, 8'hE0, 2};
        vecs[5]  = '{3'd1, 4'd0,  8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5, 0};
        vecs[6]  = '{3'd7, 4'd0,  8'hFF, 8'h12, 1'b0, 1'b0, 8'h00, 0};
        vecs[7]  = '{3'd0, 4'd5,  8'h3C, 8'hFF, 1'b1, 1'b1, 8'h3C, 0};
        vecs[8]  = '{3'd4, 4'd1,  8'h01, 8'h00, 1'b0, 1'b0, 8'h80, 1};
        vecs[9]  = '{3'd5, 4'd15, 8'h01, 8'h00, 1'b0, 1'b0, 8'h80, 15};
        vecs[10] = '{3'd1, 4'd2,  8'h96, 8'h00, 1'b0, 1'b0, 8'h25, 2};
        vecs[11] = '{3'd6, 4'd1,  8'h6B, 8'h00, 1'b0, 1'b0, 8'h35, 1};

        // Reset state, held across several clock edges.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_p_dout", {24'd0, p_dout}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // First start right after reset release; LOAD A5.
        issue(3'd3, 4'd0, 8'hA5);
        chk("first_load_p", {24'd0, p_dout}, 32'hA5);
        chk("first_load_done", {31'd0, done}, 32'd1);
        chk("first_load_busy", {31'd0, busy}, 32'd0);
        chk("first_load_sl", {31'd0, s_left_dout}, 32'd1);
        chk("first_load_sr", {31'd0, s_right_dout}, 32'd1);
        step();
        chk("first_load_done_off", {31'd0, done}, 32'd0);

        // Table of commands, each starting from a freshly loaded value.
        for (int i = 0; i < 12; i++) begin
            nm = $sformatf("vec%0d", i);
            issue(3'd3, 4'd0, vecs[i].init);
            step();
            s_left_din  = vecs[i].sl;
            s_right_din = vecs[i].sr;
            issue(vecs[i].op, vecs[i].n, vecs[i].din);
            if (vecs[i].cyc > 0)
                chk({nm, "_accept_hold"}, {24'd0, p_dout}, {24'd0, vecs[i].init});
            p_din = ~vecs[i].din;
            op    = 3'd7;
            wait_done(nm, bc);
            chk({nm, "_value"}, {24'd0, p_dout}, {24'd0, vecs[i].exp});
            chk({nm, "_busy_cycles"}, bc, vecs[i].cyc);
            chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            chk({nm, "_sl_out"}, {31'd0, s_left_dout}, {31'd0, vecs[i].exp[0]});
            chk({nm, "_sr_out"}, {31'd0, s_right_dout}, {31'd0, vecs[i].exp[7]});
            step();
            chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        end

        // SHR N=3 step by step, with an ignored LOAD FF during busy.
        issue(3'd3, 4'd0, 8'hA5);
        s_right_din = 1'b1;
        issue(3'd1, 4'd3, 8'h00);
        chk("seq_shr_hold", {24'd0, p_dout}, 32'hA5);
        chk("seq_shr_busy0", {31'd0, busy}, 32'd1);
        issue(3'd3, 4'd0, 8'hFF);
        chk("seq_shr_s1", {24'd0, p_dout}, 32'hD2);
        step();
        chk("seq_shr_s2", {24'd0, p_dout}, 32'hE9);
        chk("seq_shr_busy2", {31'd0, busy}, 32'd1);
        chk("seq_shr_nodone", {31'd0, done}, 32'd0);
        step();
        chk("seq_shr_s3", {24'd0, p_dout}, 32'hF4);
        chk("seq_shr_done", {31'd0, done}, 32'd1);
        chk("seq_shr_idle", {31'd0, busy}, 32'd0);
        step();
        chk("seq_shr_after", {24'd0, p_dout}, 32'hF4);
        chk("seq_shr_done_off", {31'd0, done}, 32'd0);

        // Reset during the 2nd cycle of SHL N=5 takes effect without a clock edge.
        issue(3'd3, 4'd0, 8'h81);
        s_left_din = 1'b1;
        issue(3'd2, 4'd5, 8'h00);
        step();
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_p", {24'd0, p_dout}, 32'h00);
        chk("rst_mid_busy_off", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rst_no_done%0d", k), {30'd0, busy, done}, 32'd0);
            step();
        end
        issue(3'd3, 4'd0, 8'h3C);
        chk("rst_reload_p", {24'd0, p_dout}, 32'h3C);
        chk("rst_reload_done", {31'd0, done}, 32'd1);

        // CLEAR from FF, then back-to-back commands issued in each done cycle.
        step();
        issue(3'd3, 4'd0, 8'hFF);
        step();
        issue(3'd7, 4'd0, 8'h55);
        chk("clear_p", {24'd0, p_dout}, 32'h00);
        chk("clear_done", {31'd0, done}, 32'd1);
        issue(3'd4, 4'd1, 8'h00);
        chk("b2b_ror0_busy", {31'd0, busy}, 32'd1);
        chk("b2b_ror0_done_off", {31'd0, done}, 32'd0);
        step();
        chk("b2b_ror0_p", {24'd0, p_dout}, 32'h00);
        chk("b2b_ror0_done", {31'd0, done}, 32'd1);
        issue(3'd3, 4'd0, 8'h01);
        chk("b2b_load_p", {24'd0, p_dout}, 32'h01);
        chk("b2b_load_done", {31'd0, done}, 32'd1);
        issue(3'd4, 4'd1, 8'h00);
        chk("b2b_ror_busy", {31'd0, busy}, 32'd1);
        chk("b2b_ror_hold", {24'd0, p_dout}, 32'h01);
        step();
        chk("b2b_ror_p", {24'd0, p_dout}, 32'h80);
        chk("b2b_ror_done", {31'd0, done}, 32'd1);
        chk("b2b_ror_sr", {31'd0, s_right_dout}, 32'd1);
        step();
        chk("b2b_ror_done_off", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
